// File: rtl/mem_pkg.sv
// Shared types for the RAM-backed FIFO controller.
// Output-stage state encoding and the RAM read latency.
package mem_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  localparam int RAM_RD_LAT = 1;

endpackage

// File: rtl/fifo_out_stage.sv
// Two-entry output buffer fed by RAM read returns.
// Ports: capture/cap_data in, pop in, valid/head/stage_cnt out.
module fifo_out_stage
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        stage_cnt
);

  stage_state_e      state_q;
  stage_state_e      state_d;
  logic [DATA_W-1:0] d0_q;
  logic [DATA_W-1:0] d1_q;
  logic [DATA_W-1:0] d0_d;
  logic [DATA_W-1:0] d1_d;

  always_comb begin
    state_d = state_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    unique case (state_q)
      EMPTY: begin
        if (capture) begin
          d0_d    = cap_data;
          state_d = ONE;
        end
      end
      ONE: begin
        unique case ({capture, pop})
          2'b10: begin
            d1_d    = cap_data;
            state_d = TWO;
          end
          2'b01: state_d = EMPTY;
          // Head leaves as the new word arrives
          2'b11: d0_d = cap_data;
          default: ;
        endcase
      end
      TWO: begin
        if (pop) begin
          d0_d = d1_q;
          if (capture) d1_d = cap_data;
          else state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      d0_q    <= '0;
      d1_q    <= '0;
    end else begin
      state_q <= state_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
    end
  end

  assign valid     = (state_q != EMPTY);
  assign head      = d0_q;
  assign stage_cnt = {state_q == TWO,
                      state_q == ONE};

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a 1-cycle-latency SDP RAM.
// Ports: s_* input stream, m_* output stream, ram_* RAM side, count_o.
module ram_fifo_ctrl
  import mem_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 256,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [CW-1:0]     count_o,
  output logic              ram_wen_o,
  output logic [AW-1:0]     ram_waddr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_ren_o,
  output logic [AW-1:0]     ram_raddr_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   ram_cnt_q;
  logic          rd_pend_q;
  logic [CW-1:0] count_q;
  logic [1:0]    stage_cnt;
  logic [2:0]    occ;
  logic          push;
  logic          pop;

  assign s_ready_o = rst_n &&
    (ram_cnt_q < (AW+1)'(DEPTH));
  assign push = s_valid_i && s_ready_o;
  assign pop  = m_valid_o && m_ready_i;

  // Stage words plus the read in flight
  assign occ = {1'b0, stage_cnt} +
               {2'b00, rd_pend_q};

  assign ram_ren_o = rst_n &&
    (ram_cnt_q != '0) &&
    (occ < (3'd2 + {2'b00, pop}));

  assign ram_wen_o   = push;
  assign ram_waddr_o = wptr_q;
  assign ram_wdata_o = s_data_i;
  assign ram_raddr_o = rptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      count_q   <= '0;
    end else begin
      if (push)      wptr_q <= wptr_q + AW'(1);
      if (ram_ren_o) rptr_q <= rptr_q + AW'(1);
      unique case ({push, ram_ren_o})
        2'b10:   ram_cnt_q <= ram_cnt_q + 1'b1;
        2'b01:   ram_cnt_q <= ram_cnt_q - 1'b1;
        default: ;
      endcase
      rd_pend_q <= ram_ren_o;
      // Total held only moves on the stream handshakes
      count_q <= count_q + CW'(push)
                         - CW'(pop);
    end
  end

  assign count_o = count_q;

  fifo_out_stage #(
    .DATA_W (DATA_W)
  ) u_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (rd_pend_q),
    .cap_data  (ram_rdata_i),
    .pop       (pop),
    .valid     (m_valid_o),
    .head      (m_data_o),
    .stage_cnt (stage_cnt)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural SDP RAM, DEPTH=8.
// Queue scoreboard plus directed latency/capacity/reset steps.
module tb_ram_fifo_ctrl;

  localparam int DW = 32;
  localparam int DP = 8;
  localparam int AW = 3;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] count;
  logic          ram_wen;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          ram_ren;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [DP];

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] q [$];
  int            wr_idx;
  int            rd_idx;
  bit            hold;
  logic [DW-1:0] held;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  ram_fifo_ctrl #(
    .DATA_W (DW),
    .DEPTH  (DP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .s_data_i    (s_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data),
    .count_o     (count),
    .ram_wen_o   (ram_wen),
    .ram_waddr_o (ram_waddr),
    .ram_wdata_o (ram_wdata),
    .ram_ren_o   (ram_ren),
    .ram_raddr_o (ram_raddr),
    .ram_rdata_i (ram_rdata)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Check settled outputs, clock once, update the model.
  task automatic tick();
    bit psh;
    bit pp;
    bit rn;
    psh = s_valid && s_ready;
    pp  = m_valid && m_ready;
    rn  = ram_ren;
    if (!rst_n) begin
      chk("rst_s_ready", s_ready, 0);
      chk("rst_wen", ram_wen, 0);
      chk("rst_ren", ram_ren, 0);
    end else begin
      chk("count", count, q.size());
      if (q.size() < DP)
        chk("ready_room", s_ready, 1);
      if (q.size() == DP + 2)
        chk("ready_full", s_ready, 0);
      if (q.size() == 0)
        chk("empty_valid", m_valid, 0);
      if (psh) begin
        chk("waddr", ram_waddr, wr_idx % DP);
        chk("wdata", ram_wdata, s_data);
      end
      if (rn)
        chk("raddr", ram_raddr, rd_idx % DP);
      if (hold) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, held);
      end
      if (pp && q.size() > 0)
        chk("pop_data", m_data, q[0]);
    end
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      wr_idx = 0;
      rd_idx = 0;
      hold   = 0;
    end else begin
      if (pp && q.size() > 0) void'(q.pop_front());
      if (psh) q.push_back(s_data);
      wr_idx += int'(psh);
      rd_idx += int'(rn);
      hold = m_valid && !m_ready;
      held = m_data;
    end
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int b;
    b = 0;
    s_valid = 0;
    m_ready = 1;
    #1;
    while (q.size() != 0 && b < 40) begin
      tick();
      #1;
      b++;
    end
    chk({tag, "_left"}, q.size(), 0);
    chk({tag, "_cnt"}, count, 0);
  endtask

  initial begin
    int n;
    int b;
    bit burst;
    rst_n   = 0;
    s_valid = 1;
    s_data  = 32'h1234_5678;
    m_ready = 1;
    wr_idx  = 0;
    rd_idx  = 0;
    hold    = 0;
    @(negedge clk);

    // 1: reset with s_valid high
    #1;
    tick();
    #1;
    chk("rst_mvalid", m_valid, 0);
    chk("rst_count", count, 0);
    tick();
    rst_n   = 1;
    s_valid = 0;
    #1;
    chk("rel_ready", s_ready, 1);
    tick();

    // 2: single-word latency
    s_valid = 1;
    s_data  = 32'hA5A5_0001;
    m_ready = 1;
    #1;
    chk("lat_wen", ram_wen, 1);
    chk("lat_waddr", ram_waddr, 0);
    chk("lat_v0", m_valid, 0);
    tick();
    s_valid = 0;
    #1;
    chk("lat_ren", ram_ren, 1);
    chk("lat_raddr", ram_raddr, 0);
    chk("lat_v1", m_valid, 0);
    tick();
    #1;
    chk("lat_v2", m_valid, 0);
    tick();
    #1;
    chk("lat_v3", m_valid, 1);
    chk("lat_d3", m_data, 32'hA5A5_0001);
    tick();
    #1;
    chk("lat_cnt0", count, 0);
    chk("lat_v4", m_valid, 0);

    // 3: fill to capacity with the consumer stalled
    m_ready = 0;
    s_valid = 1;
    n = 0;
    while (n < 20) begin
      s_data = n;
      #1;
      if (!s_ready) break;
      tick();
      n++;
    end
    chk("fill_words", n, DP + 2);
    chk("fill_cnt", count, DP + 2);
    drain("fill_drain");

    // 4: full-rate stream
    for (int k = 0; k < 103; k++) begin
      s_valid = (k < 100);
      s_data  = 32'h1000 + k;
      m_ready = 1;
      #1;
      if (k < 3) chk("strm_lat", m_valid, 0);
      else chk("strm_tput", m_valid, 1);
      tick();
    end
    drain("strm_drain");

    // 5: alternating consumer, bursty producer
    burst = 0;
    for (int k = 0; k < 300; k++) begin
      if (k % 8 == 0)
        burst = ($urandom_range(0, 1) == 1);
      m_ready = (k % 2 == 0);
      s_valid = burst &&
                ($urandom_range(0, 3) != 0);
      s_data  = $urandom;
      #1;
      tick();
    end
    drain("rand_drain");

    // 6: reset mid-operation
    m_ready = 0;
    s_valid = 1;
    for (int k = 0; k < 5; k++) begin
      s_data = 32'hC0DE_0000 + k;
      #1;
      tick();
    end
    chk("pre_rst_cnt", count, 5);
    rst_n   = 0;
    s_valid = 0;
    #1;
    tick();
    rst_n = 1;
    #1;
    chk("post_rst_cnt", count, 0);
    chk("post_rst_v", m_valid, 0);
    s_valid = 1;
    s_data  = 32'h0000_BEEF;
    #1;
    chk("post_rst_waddr", ram_waddr, 0);
    tick();
    s_valid = 0;
    m_ready = 1;
    #1;
    b = 0;
    while (!m_valid && b < 10) begin
      tick();
      #1;
      b++;
    end
    chk("post_rst_v1", m_valid, 1);
    chk("post_rst_d", m_data, 32'h0000_BEEF);
    tick();
    drain("end_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
